ha_resp_chk: RTL and testbench

HA_RESP_CHK -- requirements
Module: ha_resp_chk

---
 rtl/ha_chk_pkg.sv | 20 ++
 rtl/ha_chk_dly.sv | 36 +++
 rtl/ha_resp_chk.sv | 136 +++++++++++++
 tb/tb_ha_resp_chk.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_chk_pkg.sv
// rtl/ha_chk_pkg.sv - shared types and constants for the half-adder response checker
package ha_chk_pkg;

    // Captured vector: stimulus a/b plus the DUT's s/ca response.
    typedef struct packed {
        logic a;
        logic b;
        logic s;
        logic ca;
    } ha_vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] ERR_SAT = 8'd255;

endpackage

// File: rtl/ha_chk_dly.sv
// rtl/ha_chk_dly.sv - DLY-deep valid+{a,b} delay line aligning stimulus with the DUT response
module ha_chk_dly #(
    parameter int DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic in_a,
    input  logic in_b,
    output logic out_valid,
    output logic out_a,
    output logic out_b
);

    // Each stage holds {valid, a, b}; data is zeroed when not valid.
    logic [2:0] stage [DLY];

    // Shift the stimulus; clr flushes older entries while the head still takes the
    // incoming sample so a sample coinciding with start becomes the first of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) begin
                stage[i] <= 3'b000;
            end
        end else begin
            stage[0] <= {in_valid, in_a & in_valid, in_b & in_valid};
            for (int i = 1; i < DLY; i++) begin
                stage[i] <= clr ? 3'b000 : stage[i-1];
            end
        end
    end

    assign {out_valid, out_a, out_b} = stage[DLY-1];

endmodule

// File: rtl/ha_resp_chk.sv
// rtl/ha_resp_chk.sv - half-adder response checker top; HA_RESP_CHK_COVER_EN adds {a,b} coverage port cov
module ha_resp_chk
    import ha_chk_pkg::*;
#(
    parameter int NUM_VEC = 4,
    parameter int DLY     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sample,
    input  logic       a,
    input  logic       b,
    input  logic       s,
    input  logic       ca,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] vec_cnt,
    output ha_vec_t    fail_vec
`ifdef HA_RESP_CHK_COVER_EN
    ,
    output logic [3:0] cov
`endif
);

    localparam logic [7:0] NUM_VEC_B = 8'(NUM_VEC);

    state_t     state;
    logic [7:0] acc_cnt;

    logic       run_start;
    logic       accept;
    logic       dly_valid;
    logic       dly_a;
    logic       dly_b;
    logic       cmp;
    logic       mism;
    logic [7:0] err_nxt;
    logic [7:0] vec_nxt;
    logic       last_cmp;
    logic       pass_nxt;
`ifdef HA_RESP_CHK_COVER_EN
    logic [3:0] cov_nxt;
`endif

    ha_chk_dly #(
        .DLY (DLY)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .clr       (run_start),
        .in_valid  (accept),
        .in_a      (a),
        .in_b      (b),
        .out_valid (dly_valid),
        .out_a     (dly_a),
        .out_b     (dly_b)
    );

    // Accept/compare decisions and next counter values for the current cycle.
    always_comb begin
        run_start = start && (state != RUN);
        accept    = sample && (run_start || ((state == RUN) && (acc_cnt < NUM_VEC_B)));
        cmp       = (state == RUN) && dly_valid;
        mism      = cmp && ((s != (dly_a ^ dly_b)) || (ca != (dly_a & dly_b)));
        err_nxt   = (mism && (err_cnt != ERR_SAT)) ? err_cnt + 8'd1 : err_cnt;
        vec_nxt   = cmp ? vec_cnt + 8'd1 : vec_cnt;
        last_cmp  = cmp && (vec_nxt == NUM_VEC_B);
`ifdef HA_RESP_CHK_COVER_EN
        cov_nxt   = cmp ? (cov | (4'b0001 << {dly_a, dly_b})) : cov;
        pass_nxt  = (err_nxt == 8'd0) && (cov_nxt == 4'hF);
`else
        pass_nxt  = (err_nxt == 8'd0);
`endif
    end

    // Run control FSM with registered result outputs; start inside RUN is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc_cnt  <= 8'd0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= 8'd0;
            vec_cnt  <= 8'd0;
            fail_vec <= '0;
`ifdef HA_RESP_CHK_COVER_EN
            cov      <= 4'h0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        acc_cnt  <= accept ? 8'd1 : 8'd0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= 8'd0;
                        vec_cnt  <= 8'd0;
                        fail_vec <= '0;
`ifdef HA_RESP_CHK_COVER_EN
                        cov      <= 4'h0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + 8'd1;
                    end
                    vec_cnt <= vec_nxt;
                    err_cnt <= err_nxt;
`ifdef HA_RESP_CHK_COVER_EN
                    cov     <= cov_nxt;
`endif
                    // err_cnt never returns to zero within a run, so this captures only the first miss.
                    if (mism && (err_cnt == 8'd0)) begin
                        fail_vec.a  <= dly_a;
                        fail_vec.b  <= dly_b;
                        fail_vec.s  <= s;
                        fail_vec.ca <= ca;
                    end
                    if (last_cmp) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= pass_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ha_resp_chk.sv
// tb/tb_ha_resp_chk.sv - scoreboard bench for ha_resp_chk (NUM_VEC=4 and NUM_VEC=255 instances)
module tb_ha_resp_chk;
    import ha_chk_pkg::*;

    localparam int DLY = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4;
    logic       start255;
    logic       sample;
    logic       a;
    logic       b;
    logic       fc;
    logic       fs;
    logic       s;
    logic       ca;

    logic       done4, pass4, done255, pass255;
    logic [7:0] err4, vec4, err255, vec255;
    ha_vec_t    fv4, fv255;
`ifdef HA_RESP_CHK_COVER_EN
    logic [3:0] cov4, cov255;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [7:0] vec;
        logic [3:0] fv;
        logic [3:0] cov;
        int         cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q255[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the half adder being checked: DLY-cycle pipeline, faults travel with the vector.
    logic [3:0] pipe [DLY];
    always @(posedge clk) begin
        pipe[0] <= {a, b, fc, fs};
        for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
    end
    assign s  = (pipe[DLY-1][3] ^ pipe[DLY-1][2]) ^ pipe[DLY-1][0];
    assign ca = (pipe[DLY-1][3] & pipe[DLY-1][2]) & ~pipe[DLY-1][1];

    ha_resp_chk #(.NUM_VEC(4), .DLY(DLY)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sample(sample), .a(a), .b(b),
        .s(s), .ca(ca), .done(done4), .pass(pass4), .err_cnt(err4),
        .vec_cnt(vec4), .fail_vec(fv4)
`ifdef HA_RESP_CHK_COVER_EN
        , .cov(cov4)
`endif
    );

    ha_resp_chk #(.NUM_VEC(255), .DLY(DLY)) dut255 (
        .clk(clk), .rst(rst), .start(start255), .sample(sample), .a(a), .b(b),
        .s(s), .ca(ca), .done(done255), .pass(pass255), .err_cnt(err255),
        .vec_cnt(vec255), .fail_vec(fv255)
`ifdef HA_RESP_CHK_COVER_EN
        , .cov(cov255)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [7:0] er, input logic [7:0] vc,
                                input logic [3:0] fv, input logic [3:0] cv, input int c);
        exp_t e;
        e.pass = p; e.err = er; e.vec = vc; e.fv = fv; e.cov = cv; e.cyc = c;
        return e;
    endfunction

    task automatic cmp_res(input string tag, input exp_t e, input logic p, input logic [7:0] er,
                           input logic [7:0] vc, input logic [3:0] fv, input int c);
        chk({tag, "_pass"},     32'(p),  32'(e.pass));
        chk({tag, "_err_cnt"},  32'(er), 32'(e.err));
        chk({tag, "_vec_cnt"},  32'(vc), 32'(e.vec));
        chk({tag, "_fail_vec"}, 32'(fv), 32'(e.fv));
        chk({tag, "_done_cyc"}, 32'(c),  32'(e.cyc));
    endtask

    // Monitor: on each rising done, pop the expected result and compare.
    initial begin
        exp_t e;
        logic d4q;
        logic d255q;
        d4q   = 1'b0;
        d255q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d4q   = 1'b0;
                d255q = 1'b0;
            end else begin
                if (done4 && !d4q) begin
                    if (q4.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL d4_done: got unexpected done at cycle %0d, expected none", cyc);
                    end else begin
                        e = q4.pop_front();
                        cmp_res("d4", e, pass4, err4, vec4, fv4, cyc);
`ifdef HA_RESP_CHK_COVER_EN
                        chk("d4_cov", 32'(cov4), 32'(e.cov));
`endif
                    end
                end
                if (done255 && !d255q) begin
                    if (q255.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL d255_done: got unexpected done at cycle %0d, expected none", cyc);
                    end else begin
                        e = q255.pop_front();
                        cmp_res("d255", e, pass255, err255, vec255, fv255, cyc);
`ifdef HA_RESP_CHK_COVER_EN
                        chk("d255_cov", 32'(cov255), 32'(e.cov));
`endif
                    end
                end
                d4q   = done4;
                d255q = done255;
            end
        end
    end

    task automatic drv(input logic st4, input logic st255, input logic smp, input logic av,
                       input logic bv, input logic f_c, input logic f_s);
        @(negedge clk);
        start4 = st4; start255 = st255; sample = smp;
        a = av; b = bv; fc = f_c; fs = f_s;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic put(input logic av, input logic bv, input logic f_c, input logic f_s);
        drv(0, 0, 1, av, bv, f_c, f_s);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((q4.size() != 0 || q255.size() != 0) && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (q4.size() != 0 || q255.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results pending, expected 0", q4.size() + q255.size());
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start4 = 0; start255 = 0; sample = 0; a = 0; b = 0; fc = 0; fs = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_done",     32'(done4),   0);
        chk("rst_pass",     32'(pass4),   0);
        chk("rst_err_cnt",  32'(err4),    0);
        chk("rst_vec_cnt",  32'(vec4),    0);
        chk("rst_fail_vec", 32'(fv4),     0);
        chk("rst_done255",  32'(done255), 0);

        // Good DUT, start then 00,10,01,11.
        drv(1, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0); put(1, 0, 0, 0); put(0, 1, 0, 0); put(1, 1, 0, 0);
        q4.push_back(mk(1, 8'd0, 8'd4, 4'h0, 4'hF, cyc + DLY + 1));
        idle(1);
        wait_drain();

        // Start coincident with first sample; ca stuck at 0 on 11.
        drv(1, 0, 1, 0, 0, 0, 0);
        put(1, 0, 0, 0); put(0, 1, 0, 0); put(1, 1, 1, 0);
        q4.push_back(mk(0, 8'd1, 8'd4, 4'b1100, 4'hF, cyc + DLY + 1));
        idle(1);
        wait_drain();
        idle(3);
        chk("done_held", 32'(done4), 1);

        // Start clears results; start in RUN ignored; samples past NUM_VEC ignored.
        drv(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("start_clr_done",    32'(done4), 0);
        chk("start_clr_err_cnt", 32'(err4),  0);
        chk("start_clr_fail",    32'(fv4),   0);
        put(1, 1, 0, 0); put(0, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        put(1, 0, 0, 0);
        chk("run_start_ignored", 32'(vec4), 1);
        put(0, 0, 0, 0);
        q4.push_back(mk(1, 8'd0, 8'd4, 4'h0, 4'hF, cyc + DLY + 1));
        put(1, 1, 0, 1); put(1, 1, 0, 1);
        idle(1);
        wait_drain();

        // Reset mid-run with samples in flight.
        drv(1, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0); put(1, 0, 0, 0);
        idle(1);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_done",     32'(done4),       0);
        chk("midrst_pass",     32'(pass4),       0);
        chk("midrst_err_cnt",  32'(err4),        0);
        chk("midrst_vec_cnt",  32'(vec4),        0);
        chk("midrst_fail_vec", 32'(fv4),         0);
        chk("midrst_state",    32'(dut4.state),  32'(IDLE));
        put(1, 1, 0, 1);
        idle(4);
        chk("idle_sample_ignored", 32'(vec4), 0);
        chk("idle_no_done",        32'(done4), 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0); put(1, 0, 0, 0); put(0, 1, 0, 0); put(1, 1, 0, 0);
        q4.push_back(mk(1, 8'd0, 8'd4, 4'h0, 4'hF, cyc + DLY + 1));
        idle(1);
        wait_drain();

        // 300 vectors with s inverted on the NUM_VEC=255 instance.
        drv(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            put(1'(i % 2), 1'((i / 2) % 2), 0, 1);
            if (i == 254) q255.push_back(mk(0, 8'd255, 8'd255, 4'b0010, 4'hF, cyc + DLY + 1));
        end
        idle(1);
        wait_drain();
        idle(3);
        chk("sat_err_cnt_hold", 32'(err255), 255);
        chk("sat_vec_cnt_hold", 32'(vec255), 255);
        chk("d4_untouched_vec", 32'(vec4),   4);

`ifdef HA_RESP_CHK_COVER_EN
        // Only {0,0} compared: coverage incomplete so pass stays low.
        drv(1, 0, 0, 0, 0, 0, 0);
        put(0, 0, 0, 0); put(0, 0, 0, 0); put(0, 0, 0, 0); put(0, 0, 0, 0);
        q4.push_back(mk(0, 8'd0, 8'd4, 4'h0, 4'b0001, cyc + DLY + 1));
        idle(1);
        wait_drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
